// File: rtl/vga_timing_if.sv
// Timing-controller bundle: run request in, raster position/sync/strobes out.
interface vga_timing_if #(
    parameter int unsigned X_W = 10,
    parameter int unsigned Y_W = 10
);
    logic           en;
    logic           running;
    logic           pix_tick;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           hsync;
    logic           vsync;
    logic           video_on;
    logic           line_start;
    logic           frame_start;

    // Timing controller side
    modport master (
        input  en,
        output running, pix_tick, x, y, hsync, vsync, video_on, line_start, frame_start
    );

    // Pixel generator / requester side
    modport slave (
        output en,
        input  running, pix_tick, x, y, hsync, vsync, video_on, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA frame/line timing: pixel-clock-enable divider, x/y raster counters,
// sync/blanking decode and a start/stop handshake aligned to frame boundaries.
module vga_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 4,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 10
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master tim
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [X_W-1:0]   X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Elaboration-time sanity of parameters against counter widths
    if (CLK_DIV < 1) begin : g_bad_div
        $error("CLK_DIV must be at least 1");
    end
    if (H_TOTAL > (32'd1 << X_W)) begin : g_bad_xw
        $error("X_W too narrow to hold H_TOTAL-1");
    end
    if (V_TOTAL > (32'd1 << Y_W)) begin : g_bad_yw
        $error("Y_W too narrow to hold V_TOTAL-1");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             running_q, running_d;
    logic             pix_tick_q, pix_tick_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    // Next-state: FSM, divider, raster counters, and decode from next counters
    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                div_d = '0;
                x_d   = '0;
                y_d   = '0;
                if (tim.en) begin
                    state_d       = RUN;
                    line_start_d  = 1'b1;
                    frame_start_d = 1'b1;
                end
            end
            RUN, STOPPING: begin
                state_d = tim.en ? RUN : STOPPING;
                div_d   = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
                if (pix_tick_q) begin
                    if (x_q == X_LAST) begin
                        x_d          = '0;
                        line_start_d = 1'b1;
                        if (y_q == Y_LAST) begin
                            y_d = '0;
                            // A pending stop retires exactly at the frame wrap
                            if (state_q == STOPPING && !tim.en) begin
                                state_d      = IDLE;
                                div_d        = '0;
                                line_start_d = 1'b0;
                            end else begin
                                frame_start_d = 1'b1;
                            end
                        end else begin
                            y_d = y_q + Y_W'(1);
                        end
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = '0;
                x_d     = '0;
                y_d     = '0;
            end
        endcase

        running_d  = (state_d != IDLE);
        pix_tick_d = running_d && (div_d == DIV_LAST);
        video_on_d = running_d && (32'(x_d) < H_ACTIVE) && (32'(y_d) < V_ACTIVE);
        hsync_d    = (running_d && (32'(x_d) >= HS_START) && (32'(x_d) < HS_END))
                     ? HS_POL : ~HS_POL;
        vsync_d    = (running_d && (32'(y_d) >= VS_START) && (32'(y_d) < VS_END))
                     ? VS_POL : ~VS_POL;
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            div_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            running_q     <= 1'b0;
            pix_tick_q    <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            running_q     <= running_d;
            pix_tick_q    <= pix_tick_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign tim.running     = running_q;
    assign tim.pix_tick    = pix_tick_q;
    assign tim.x           = x_q;
    assign tim.y           = y_q;
    assign tim.hsync       = hsync_q;
    assign tim.vsync       = vsync_q;
    assign tim.video_on    = video_on_q;
    assign tim.line_start  = line_start_q;
    assign tim.frame_start = frame_start_q;

endmodule
